// File: rtl/exu.sv
// exu: execute stage -- operand select, alu, branch/jump resolve, result register.
// Define EXU_SKID_EN for the 2-entry skid buffer with a registered in_ready.
package alu_pkgs;
   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_EQ
   } alu_op_t;
endpackage

module alu
   import alu_pkgs::*;
#(
   parameter int WIDTH = 32
) (
   input  alu_op_t            op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic [WIDTH-1:0]   y
);
   localparam int SW = $clog2(WIDTH);

   logic [SW-1:0] sh;
   assign sh = b[SW-1:0];

   always_comb begin
      y = '0;
      case (op)
         ALU_ADD:  y = a + b;
         ALU_SUB:  y = a - b;
         ALU_SLL:  y = a << sh;
         ALU_SLT:  y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
         ALU_SLTU: y = {{(WIDTH-1){1'b0}}, a < b};
         ALU_XOR:  y = a ^ b;
         ALU_SRL:  y = a >> sh;
         ALU_SRA:  y = $unsigned($signed(a) >>> sh);
         ALU_OR:   y = a | b;
         ALU_AND:  y = a & b;
         ALU_EQ:   y = {{(WIDTH-1){1'b0}}, a == b};
         default:  y = '0;
      endcase
   end
endmodule

module exu
   import alu_pkgs::*;
#(
   parameter int WIDTH  = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_pc,
   input  logic [WIDTH-1:0]  in_rs1,
   input  logic [WIDTH-1:0]  in_rs2,
   input  logic [WIDTH-1:0]  in_imm,
   input  logic [1:0]        in_a_sel,
   input  logic              in_b_sel,
   input  alu_op_t           in_alu_op,
   input  logic [2:0]        in_br,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_wen,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_result,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_wen,
   output logic              redirect_valid,
   output logic [WIDTH-1:0]  redirect_pc
);
   localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_y;
   logic [WIDTH-1:0] br_tgt;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] tgt_d;
   logic             wen_d;
   logic             taken_d;
   logic             is_jmp;
   logic             is_br;
   logic             acc;

   always_comb begin
      op_a = '0;
      unique case (in_a_sel)
         2'd0:    op_a = in_rs1;
         2'd1:    op_a = in_pc;
         default: op_a = '0;
      endcase
   end

   assign op_b   = in_b_sel ? in_imm : in_rs2;
   assign br_tgt = in_pc + in_imm;
   assign is_jmp = (in_br == 3'd7);
   assign is_br  = (in_br != 3'd0) && !is_jmp;

   alu #(.WIDTH(WIDTH)) u_alu (
      .op (in_alu_op),
      .a  (op_a),
      .b  (op_b),
      .y  (alu_y)
   );

   // odd br codes take on a true compare, even codes on a false one
   always_comb begin
      res_d   = alu_y;
      wen_d   = in_wen;
      taken_d = 1'b0;
      tgt_d   = br_tgt;
      unique case (1'b1)
         is_jmp: begin
            res_d   = in_pc + FOUR;
            taken_d = 1'b1;
            tgt_d   = {alu_y[WIDTH-1:1], 1'b0};
         end
         is_br: begin
            wen_d   = 1'b0;
            taken_d = alu_y[0] ^ ~in_br[0];
         end
         default: ;
      endcase
   end

   assign acc = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
      end else begin
         redirect_valid <= acc && taken_d;
         if (acc && taken_d) redirect_pc <= tgt_d;
      end
   end

`ifdef EXU_SKID_EN
   logic [1:0]        cnt;
   logic [1:0]        cnt_n;
   logic              drain;
   logic              rdy_q;
   logic [WIDTH-1:0]  sk_res;
   logic [REG_AW-1:0] sk_rd;
   logic              sk_wen;

   assign out_valid = (cnt != 2'd0);
   assign drain     = out_valid && out_ready;
   assign cnt_n     = cnt + {1'b0, acc} - {1'b0, drain};
   assign in_ready  = rdy_q;

   // head entry drives out_*; second entry only fills while the head is stuck
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= 2'd0;
         rdy_q      <= 1'b1;
         out_result <= '0;
         out_rd     <= '0;
         out_wen    <= 1'b0;
         sk_res     <= '0;
         sk_rd      <= '0;
         sk_wen     <= 1'b0;
      end else begin
         cnt   <= cnt_n;
         rdy_q <= (cnt_n != 2'd2) && !(acc && taken_d);
         if (acc && (cnt == 2'd0 || (cnt == 2'd1 && drain))) begin
            out_result <= res_d;
            out_rd     <= in_rd;
            out_wen    <= wen_d;
         end else if (cnt == 2'd2 && drain) begin
            out_result <= sk_res;
            out_rd     <= sk_rd;
            out_wen    <= sk_wen;
         end
         if (acc && (cnt == 2'd2 || (cnt == 2'd1 && !drain))) begin
            sk_res <= res_d;
            sk_rd  <= in_rd;
            sk_wen <= wen_d;
         end
      end
   end
`else
   assign in_ready = (!out_valid || out_ready) && !redirect_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_result <= '0;
         out_rd     <= '0;
         out_wen    <= 1'b0;
      end else if (acc) begin
         out_valid  <= 1'b1;
         out_result <= res_d;
         out_rd     <= in_rd;
         out_wen    <= wen_d;
      end else if (out_ready) begin
         out_valid  <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_exu.sv
// tb_exu: randomized scoreboard bench for exu against a spec-level model.
// Monitor pops expected results/redirects whenever the DUT presents them.
module tb_exu;
   import alu_pkgs::*;

   localparam int W  = 32;
   localparam int RA = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_pc = '0;
   logic [W-1:0]  in_rs1 = '0;
   logic [W-1:0]  in_rs2 = '0;
   logic [W-1:0]  in_imm = '0;
   logic [1:0]    in_a_sel = '0;
   logic          in_b_sel = 1'b0;
   alu_op_t       in_alu_op = ALU_ADD;
   logic [2:0]    in_br = '0;
   logic [RA-1:0] in_rd = '0;
   logic          in_wen = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  out_result;
   logic [RA-1:0] out_rd;
   logic          out_wen;
   logic          redirect_valid;
   logic [W-1:0]  redirect_pc;

   always #5 clk = ~clk;

   exu #(.WIDTH(W), .REG_AW(RA)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_imm         (in_imm),
      .in_a_sel       (in_a_sel),
      .in_b_sel       (in_b_sel),
      .in_alu_op      (in_alu_op),
      .in_br          (in_br),
      .in_rd          (in_rd),
      .in_wen         (in_wen),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_result     (out_result),
      .out_rd         (out_rd),
      .out_wen        (out_wen),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
   );

   typedef struct {
      logic [W-1:0]  pc, rs1, rs2, imm;
      logic [1:0]    a_sel;
      logic          b_sel;
      alu_op_t       op;
      logic [2:0]    br;
      logic [RA-1:0] rd;
      logic          wen;
   } beat_t;

   typedef struct {
      logic [W-1:0]  result;
      logic [RA-1:0] rd;
      logic          wen;
      bit            chk_res;
   } exp_t;

   typedef struct {
      int           cyc;
      logic [W-1:0] pc;
   } rexp_t;

   exp_t  sq[$];
   rexp_t rq[$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    rdy_mode = 1;
   int    stall_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string nm,
                      input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic logic [W-1:0] alu_ref(input alu_op_t op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      case (op)
         ALU_ADD:  return a + b;
         ALU_SUB:  return a - b;
         ALU_SLL:  return a << b[4:0];
         ALU_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         ALU_SLTU: return (a < b) ? 32'd1 : 32'd0;
         ALU_XOR:  return a ^ b;
         ALU_SRL:  return a >> b[4:0];
         ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
         ALU_OR:   return a | b;
         ALU_AND:  return a & b;
         ALU_EQ:   return (a == b) ? 32'd1 : 32'd0;
         default:  return '0;
      endcase
   endfunction

   // Branch outcome comes straight from the instruction's meaning.
   function automatic void model(input beat_t b, output exp_t e,
                                 output bit tk, output logic [W-1:0] tg);
      logic [W-1:0] a, bb;
      a  = (b.a_sel == 2'd0) ? b.rs1 : (b.a_sel == 2'd1) ? b.pc : '0;
      bb = b.b_sel ? b.imm : b.rs2;
      e.rd = b.rd;
      e.result = alu_ref(b.op, a, bb);
      e.wen = b.wen;
      e.chk_res = 1'b1;
      tk = 1'b0;
      tg = b.pc + b.imm;
      case (b.br)
         3'd0: ;
         3'd7: begin
            tk = 1'b1;
            tg = (a + b.imm) & 32'hFFFF_FFFE;
            e.result = b.pc + 32'd4;
         end
         default: begin
            e.wen = 1'b0;
            e.chk_res = 1'b0;
            case (b.br)
               3'd1: tk = (b.rs1 == b.rs2);
               3'd2: tk = (b.rs1 != b.rs2);
               3'd3: tk = ($signed(b.rs1) < $signed(b.rs2));
               3'd4: tk = ($signed(b.rs1) >= $signed(b.rs2));
               3'd5: tk = (b.rs1 < b.rs2);
               default: tk = (b.rs1 >= b.rs2);
            endcase
         end
      endcase
   endfunction

   function automatic beat_t mk(input logic [W-1:0] pc, rs1, rs2, imm,
                                input logic [1:0] as, input logic bs,
                                input alu_op_t op, input logic [2:0] br,
                                input logic [RA-1:0] rd, input logic wen);
      beat_t b;
      b.pc = pc; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm;
      b.a_sel = as; b.b_sel = bs; b.op = op; b.br = br;
      b.rd = rd; b.wen = wen;
      return b;
   endfunction

   function automatic beat_t rand_beat();
      beat_t b;
      int k;
      k = $urandom_range(0, 9);
      b.pc = $urandom & 32'hFFFF_FFFC;
      b.rs1 = $urandom;
      b.rs2 = ($urandom_range(0, 3) == 0) ? b.rs1 : $urandom;
      b.imm = $urandom;
      b.a_sel = 2'($urandom_range(0, 3));
      b.b_sel = 1'($urandom_range(0, 1));
      b.op = alu_op_t'(4'($urandom_range(0, 10)));
      b.br = 3'd0;
      b.rd = 5'($urandom_range(0, 31));
      b.wen = 1'($urandom_range(0, 1));
      if (k >= 6 && k <= 8) begin
         b.br = 3'($urandom_range(1, 6));
         b.a_sel = 2'd0;
         b.b_sel = 1'b0;
         b.op = (b.br <= 3'd2) ? ALU_EQ : (b.br <= 3'd4) ? ALU_SLT : ALU_SLTU;
      end else if (k == 9) begin
         b.br = 3'd7;
         b.op = ALU_ADD;
         b.a_sel = 2'($urandom_range(0, 1));
         b.b_sel = 1'b1;
      end
      return b;
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         #1;
         case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input beat_t b);
      exp_t         e;
      rexp_t        r;
      bit           tk;
      logic [W-1:0] tg;
      int           n;
      bit           done;
      n = 0;
      done = 0;
      in_pc = b.pc; in_rs1 = b.rs1; in_rs2 = b.rs2; in_imm = b.imm;
      in_a_sel = b.a_sel; in_b_sel = b.b_sel; in_alu_op = b.op;
      in_br = b.br; in_rd = b.rd; in_wen = b.wen;
      in_valid = 1'b1;
      while (!done && n < 100) begin
         #4;
         if (in_ready) begin
            model(b, e, tk, tg);
            sq.push_back(e);
            if (tk) begin
               r.cyc = cyc + 1;
               r.pc = tg;
               rq.push_back(r);
            end
            if (!out_ready) stall_acc++;
            done = 1;
         end
         @(negedge clk);
         n++;
      end
      if (!done) chk(1'b0, "accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      rdy_mode = 1;
      while ((sq.size() != 0 || rq.size() != 0) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(sq.size() == 0 && rq.size() == 0, "drain_pending",
          32'(sq.size() + rq.size()), 32'd0);
      @(negedge clk);
   endtask

   logic          prev_stall = 1'b0;
   logic [W-1:0]  prev_res;
   logic [RA-1:0] prev_rd;
   logic          prev_wen;

   initial begin
      exp_t  e;
      rexp_t r;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall)
               chk(out_valid && out_result == prev_res && out_rd == prev_rd &&
                   out_wen == prev_wen, "stall_hold", out_result, prev_res);
            if (out_valid && out_ready) begin
               if (sq.size() == 0) begin
                  chk(1'b0, "spurious_out", out_result, 32'd0);
               end else begin
                  e = sq.pop_front();
                  chk(out_rd == e.rd, "out_rd", 32'(out_rd), 32'(e.rd));
                  chk(out_wen == e.wen, "out_wen", 32'(out_wen), 32'(e.wen));
                  if (e.chk_res)
                     chk(out_result == e.result, "out_result", out_result, e.result);
               end
            end
            if (redirect_valid) begin
               chk(!in_ready, "ready_in_redirect", 32'(in_ready), 32'd0);
               if (rq.size() == 0) begin
                  chk(1'b0, "spurious_redirect", redirect_pc, 32'd0);
               end else begin
                  r = rq.pop_front();
                  chk(r.cyc == cyc, "redirect_cycle", 32'(cyc), 32'(r.cyc));
                  chk(redirect_pc == r.pc, "redirect_pc", redirect_pc, r.pc);
               end
            end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
               r = rq.pop_front();
               chk(1'b0, "redirect_missing", 32'd0, r.pc);
            end
            prev_stall = out_valid && !out_ready;
            prev_res = out_result;
            prev_rd = out_rd;
            prev_wen = out_wen;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #4;
      chk(out_valid == 1'b0, "rst_out_valid", 32'(out_valid), 32'd0);
      chk(redirect_valid == 1'b0, "rst_redirect_valid", 32'(redirect_valid), 32'd0);
      chk(out_result == '0, "rst_out_result", out_result, 32'd0);
      chk(out_rd == '0 && out_wen == 1'b0, "rst_out_rd_wen", 32'({out_rd, out_wen}), 32'd0);
      chk(redirect_pc == '0, "rst_redirect_pc", redirect_pc, 32'd0);
      chk(in_ready == 1'b1, "rst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      // ADD overflow, BLT taken, BGE not taken, JALR with bit 0 cleared
      send(mk(32'h0000_1000, 32'h7FFF_FFFF, 32'h0, 32'h1, 2'd0, 1'b1, ALU_ADD, 3'd0, 5'd5, 1'b1));
      send(mk(32'h8000_0010, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, 2'd0, 1'b0, ALU_SLT, 3'd3, 5'd7, 1'b1));
      send(mk(32'h8000_0010, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF0, 2'd0, 1'b0, ALU_SLT, 3'd4, 5'd7, 1'b1));
      send(mk(32'h8000_0100, 32'h8000_1003, 32'h0, 32'h4, 2'd0, 1'b1, ALU_ADD, 3'd7, 5'd1, 1'b1));
      drain();

      // four ADDs against a three-cycle stall
      rdy_mode = 0;
      stall_acc = 0;
      fork
         begin
            for (int i = 0; i < 4; i++)
               send(mk(32'h100, 32'(i * 16), 32'h0, 32'h3, 2'd0, 1'b1, ALU_ADD,
                       3'd0, 5'(i + 8), 1'b1));
         end
         begin
            repeat (3) @(negedge clk);
            rdy_mode = 1;
         end
      join
      chk(stall_acc >= 1 && stall_acc <= 2, "stall_accepts", 32'(stall_acc), 32'd2);
      drain();

      rdy_mode = 2;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         send(rand_beat());
      end
      drain();

      // reset while a result is stalled and a redirect is pending
      rdy_mode = 0;
      send(mk(32'h0000_0200, 32'h0, 32'h0, 32'h40, 2'd1, 1'b1, ALU_ADD, 3'd7, 5'd1, 1'b1));
      chk(out_valid && redirect_valid, "pre_reset_state",
          32'({out_valid, redirect_valid}), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      chk(out_valid == 1'b0, "midrst_out_valid", 32'(out_valid), 32'd0);
      chk(redirect_valid == 1'b0, "midrst_redirect", 32'(redirect_valid), 32'd0);
      chk(out_result == '0 && redirect_pc == '0, "midrst_data",
          out_result | redirect_pc, 32'd0);
      sq.delete();
      rq.delete();
      rst = 1'b0;
      rdy_mode = 1;
      #4;
      chk(in_ready == 1'b1, "midrst_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      send(mk(32'h300, 32'h5, 32'h6, 32'h0, 2'd0, 1'b0, ALU_SUB, 3'd0, 5'd3, 1'b1));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
